// File: rtl/data_mem_bank.sv
// -----------------------------------------------------------------------------
// data_mem_bank
// Multi-channel data memory behind the gpu data_mem_* channel ports. Each
// channel has one read path and one write path, both served by a single
// per-channel FSM (IDLE -> BUSY -> RESP -> DRAIN). The access latency is fixed
// by the LATENCY parameter (1..15).
//
// Ports
//   clk                 : clock, rising edge
//   reset               : asynchronous, active-high
//   mem_read_valid      : per-channel read request
//   mem_read_address    : per-channel read address (unpacked array)
//   mem_read_ready      : one-cycle read-complete pulse
//   mem_read_data       : per-channel read data, valid with ready, then held
//   mem_write_valid     : per-channel write request
//   mem_write_address   : per-channel write address
//   mem_write_data      : per-channel write data
//   mem_write_ready     : one-cycle write-complete pulse
//
// Optional feature (macro DATA_MEM_HOST_PORT_EN):
//   host_write_en       : host preload write strobe
//   host_write_address  : host preload address
//   host_write_data     : host preload data
//   A host write commits on the next edge and overrides any channel write
//   to the same address on that edge.
// -----------------------------------------------------------------------------
module data_mem_bank #(
    parameter int ADDR_BITS    = 8,
    parameter int DATA_BITS    = 8,
    parameter int NUM_CHANNELS = 4,
    parameter int LATENCY      = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CHANNELS-1:0] mem_read_valid,
    input  logic [ADDR_BITS-1:0]    mem_read_address [NUM_CHANNELS],
    output logic [NUM_CHANNELS-1:0] mem_read_ready,
    output logic [DATA_BITS-1:0]    mem_read_data [NUM_CHANNELS],
    input  logic [NUM_CHANNELS-1:0] mem_write_valid,
    input  logic [ADDR_BITS-1:0]    mem_write_address [NUM_CHANNELS],
    input  logic [DATA_BITS-1:0]    mem_write_data [NUM_CHANNELS],
    output logic [NUM_CHANNELS-1:0] mem_write_ready
`ifdef DATA_MEM_HOST_PORT_EN
    ,
    input  logic                    host_write_en,
    input  logic [ADDR_BITS-1:0]    host_write_address,
    input  logic [DATA_BITS-1:0]    host_write_data
`endif
);

    localparam int DEPTH = 1 << ADDR_BITS;
    // LATENCY is at most 15, so a 4-bit down-counter always suffices.
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {IDLE, BUSY, RESP, DRAIN} state_t;

    // Storage is never reset; contents survive a reset pulse.
    logic [DATA_BITS-1:0] mem [DEPTH];

    logic [NUM_CHANNELS-1:0] wr_commit;
    logic [ADDR_BITS-1:0]    wr_commit_addr [NUM_CHANNELS];
    logic [DATA_BITS-1:0]    wr_commit_data [NUM_CHANNELS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
            state_t               state_reg, state_next;
            logic [CNT_W-1:0]     cnt_reg, cnt_next;
            logic                 op_wr_reg, op_wr_next;
            logic [ADDR_BITS-1:0] addr_reg, addr_next;
            logic [DATA_BITS-1:0] wdata_reg, wdata_next;
            logic [DATA_BITS-1:0] rdata_reg;
            logic                 finishing;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                    op_wr_reg <= 1'b0;
                    addr_reg  <= '0;
                    wdata_reg <= '0;
                end else begin
                    state_reg <= state_next;
                    cnt_reg   <= cnt_next;
                    op_wr_reg <= op_wr_next;
                    addr_reg  <= addr_next;
                    wdata_reg <= wdata_next;
                end
            end

            always_comb begin
                state_next = state_reg;
                cnt_next   = cnt_reg;
                op_wr_next = op_wr_reg;
                addr_next  = addr_reg;
                wdata_next = wdata_reg;
                case (state_reg)
                    IDLE: begin
                        // Write wins when both paths request together; the read
                        // stays pending and is taken after the write drains.
                        if (mem_write_valid[gi]) begin
                            state_next = BUSY;
                            op_wr_next = 1'b1;
                            addr_next  = mem_write_address[gi];
                            wdata_next = mem_write_data[gi];
                            cnt_next   = CNT_W'(LATENCY - 1);
                        end else if (mem_read_valid[gi]) begin
                            state_next = BUSY;
                            op_wr_next = 1'b0;
                            addr_next  = mem_read_address[gi];
                            cnt_next   = CNT_W'(LATENCY - 1);
                        end
                    end
                    BUSY: begin
                        if (cnt_reg == '0) begin
                            state_next = RESP;
                        end else begin
                            cnt_next = cnt_reg - CNT_W'(1);
                        end
                    end
                    RESP: begin
                        state_next = DRAIN;
                    end
                    DRAIN: begin
                        // Hold off until the completed op's valid drops so a
                        // held request cannot be serviced twice.
                        if (op_wr_reg ? !mem_write_valid[gi] : !mem_read_valid[gi]) begin
                            state_next = IDLE;
                        end
                    end
                    default: begin
                        state_next = IDLE;
                    end
                endcase
            end

            // The BUSY->RESP edge is where the array is written or sampled.
            assign finishing = (state_reg == BUSY) && (cnt_reg == '0);

            assign wr_commit[gi]      = finishing && op_wr_reg;
            assign wr_commit_addr[gi] = addr_reg;
            assign wr_commit_data[gi] = wdata_reg;

            // Sampled with the same edge as any write commit, so a same-edge
            // write to this address is not yet visible (old value returned).
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    rdata_reg <= '0;
                end else if (finishing && !op_wr_reg) begin
                    rdata_reg <= mem[addr_reg];
                end
            end

            assign mem_read_ready[gi]  = (state_reg == RESP) && !op_wr_reg;
            assign mem_write_ready[gi] = (state_reg == RESP) && op_wr_reg;
            assign mem_read_data[gi]   = rdata_reg;
        end
    endgenerate

    // Channels are applied in ascending order so the highest index wins a
    // same-address collision; the host port is applied last to override all.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (wr_commit[i]) begin
                mem[wr_commit_addr[i]] <= wr_commit_data[i];
            end
        end
`ifdef DATA_MEM_HOST_PORT_EN
        if (host_write_en) begin
            mem[host_write_address] <= host_write_data;
        end
`endif
    end

endmodule

// File: tb/tb_data_mem_bank.sv
module tb_data_mem_bank;

    localparam int AB  = 8;
    localparam int DB  = 8;
    localparam int NC  = 4;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [NC-1:0] rv, wv, rr, wrdy;
    logic [AB-1:0] ra [NC];
    logic [AB-1:0] wa [NC];
    logic [DB-1:0] wd [NC];
    logic [DB-1:0] rdat [NC];
`ifdef DATA_MEM_HOST_PORT_EN
    logic          h_en;
    logic [AB-1:0] h_a;
    logic [DB-1:0] h_d;
`endif

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;
    bit chk_en = 1'b0;

    // Behavioural model: word array plus, per channel, the edge at which the
    // pending op must complete and what it carries.
    logic [DB-1:0] mem_model [256];
    logic [DB-1:0] exp_rdata [NC];
    int            exp_rd_edge [NC];
    int            exp_wr_edge [NC];
    logic [AB-1:0] exp_rd_addr [NC];
    logic [AB-1:0] exp_wr_addr [NC];
    logic [DB-1:0] exp_wr_data [NC];
    int            host_edge = -1;
    logic [AB-1:0] host_addr;
    logic [DB-1:0] host_data;
    logic [NC-1:0] er_v, ew_v;

    data_mem_bank #(
        .ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CHANNELS(NC), .LATENCY(LAT)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .mem_read_valid    (rv),
        .mem_read_address  (ra),
        .mem_read_ready    (rr),
        .mem_read_data     (rdat),
        .mem_write_valid   (wv),
        .mem_write_address (wa),
        .mem_write_data    (wd),
        .mem_write_ready   (wrdy)
`ifdef DATA_MEM_HOST_PORT_EN
        ,
        .host_write_en     (h_en),
        .host_write_address(h_a),
        .host_write_data   (h_d)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached at edge %0d", edge_cnt);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_cnt, act, exp);
        end
    endtask

    // Compare process: after every edge, derive what must have completed at
    // that edge and check every output.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int c = 0; c < NC; c++) begin
                er_v[c] = (exp_rd_edge[c] == edge_cnt);
                ew_v[c] = (exp_wr_edge[c] == edge_cnt);
                if (er_v[c]) exp_rdata[c] = mem_model[exp_rd_addr[c]];
            end
            for (int c = 0; c < NC; c++)
                if (ew_v[c]) mem_model[exp_wr_addr[c]] = exp_wr_data[c];
            if (host_edge == edge_cnt) mem_model[host_addr] = host_data;
            check("rd_ready", 32'(rr), 32'(er_v));
            check("wr_ready", 32'(wrdy), 32'(ew_v));
            for (int c = 0; c < NC; c++)
                check($sformatf("rd_data%0d", c), 32'(rdat[c]), 32'(exp_rdata[c]));
        end
    end

    // One handshake on one channel. The request is seen at the next edge and
    // must complete LAT edges later; address/data lines are scrambled while
    // busy. valid is held 'hold' cycles past ready, then low for 'gap' cycles.
    task automatic chan_op(input int c, input bit is_wr, input logic [AB-1:0] a,
                           input logic [DB-1:0] d, input int hold, input int gap);
        int acc, rdy;
        @(negedge clk);
        acc = edge_cnt + 1;
        rdy = acc + LAT;
        if (is_wr) begin
            wa[c] = a; wd[c] = d; wv[c] = 1'b1;
            exp_wr_addr[c] = a; exp_wr_data[c] = d; exp_wr_edge[c] = rdy;
        end else begin
            ra[c] = a; rv[c] = 1'b1;
            exp_rd_addr[c] = a; exp_rd_edge[c] = rdy;
        end
        while (edge_cnt < rdy + hold) begin
            @(negedge clk);
            if (edge_cnt >= acc) begin
                wa[c] = AB'($urandom); wd[c] = DB'($urandom); ra[c] = AB'($urandom);
            end
        end
        if (is_wr) wv[c] = 1'b0; else rv[c] = 1'b0;
        $display("ch%0d %s addr=%02h wdata=%02h rdata=%02h done_edge=%0d",
                 c, is_wr ? "WR" : "RD", a, d, rdat[c], rdy);
        repeat (gap) @(negedge clk);
    endtask

    task automatic preload_chan(input int c);
        for (int i = 0; i < 64; i++) chan_op(c, 1'b1, AB'(c * 64 + i), DB'($urandom), 0, 2);
    endtask

    task automatic rand_chan(input int c, input int n);
        for (int i = 0; i < n; i++)
            chan_op(c, 1'($urandom_range(0, 1)), AB'($urandom_range(0, 15)), DB'($urandom),
                    int'($urandom_range(0, 2)), int'($urandom_range(2, 4)));
    endtask

    initial begin
        int a;
        reset = 1'b1;
        rv = '0; wv = '0;
        for (int c = 0; c < NC; c++) begin
            ra[c] = '0; wa[c] = '0; wd[c] = '0;
            exp_rd_edge[c] = -1; exp_wr_edge[c] = -1; exp_rdata[c] = '0;
        end
`ifdef DATA_MEM_HOST_PORT_EN
        h_en = 1'b0; h_a = '0; h_d = '0;
`endif
        repeat (3) @(negedge clk);
        check("reset_rd_ready", 32'(rr), 32'h0);
        check("reset_wr_ready", 32'(wrdy), 32'h0);
        for (int c = 0; c < NC; c++) check($sformatf("reset_rd_data%0d", c), 32'(rdat[c]), 32'h0);
        reset = 1'b0;
        chk_en = 1'b1;

        // Fill every word so all later reads have a known model value.
        fork
            preload_chan(0); preload_chan(1); preload_chan(2); preload_chan(3);
        join

        // Basic write then read on ch0.
        chan_op(0, 1'b1, 8'h10, 8'hA5, 0, 2);
        chan_op(0, 1'b0, 8'h10, 8'h00, 0, 2);
        check("lit_rd_0x10", 32'(rdat[0]), 32'hA5);

        // Four simultaneous reads.
        for (int c = 0; c < NC; c++) chan_op(c, 1'b1, AB'(c), DB'(7 + c), 0, 2);
        fork
            chan_op(0, 1'b0, 8'h00, 8'h00, 0, 2);
            chan_op(1, 1'b0, 8'h01, 8'h00, 0, 2);
            chan_op(2, 1'b0, 8'h02, 8'h00, 0, 2);
            chan_op(3, 1'b0, 8'h03, 8'h00, 0, 2);
        join
        for (int c = 0; c < NC; c++) check($sformatf("lit_par_rd%0d", c), 32'(rdat[c]), 32'(7 + c));

        // Same-edge writes to one address: highest channel wins.
        fork
            chan_op(1, 1'b1, 8'h20, 8'h11, 0, 2);
            chan_op(3, 1'b1, 8'h20, 8'h33, 0, 2);
        join
        chan_op(0, 1'b0, 8'h20, 8'h00, 0, 2);
        check("lit_wr_collide", 32'(rdat[0]), 32'h33);

        // Same-edge read and write to one address: read sees the old value.
        chan_op(0, 1'b1, 8'h50, 8'h12, 0, 2);
        fork
            chan_op(2, 1'b0, 8'h50, 8'h00, 0, 2);
            chan_op(0, 1'b1, 8'h50, 8'h99, 0, 2);
        join
        check("lit_rw_old", 32'(rdat[2]), 32'h12);
        chan_op(2, 1'b0, 8'h50, 8'h00, 0, 2);
        check("lit_rw_new", 32'(rdat[2]), 32'h99);

        // Read and write valid together on ch0: write first, read after drain.
        @(negedge clk);
        a = edge_cnt + 1;
        wa[0] = 8'h05; wd[0] = 8'h44; wv[0] = 1'b1; ra[0] = 8'h05; rv[0] = 1'b1;
        exp_wr_addr[0] = 8'h05; exp_wr_data[0] = 8'h44; exp_wr_edge[0] = a + LAT;
        exp_rd_addr[0] = 8'h05; exp_rd_edge[0] = a + LAT + 3 + LAT;
        while (edge_cnt < a + LAT) @(negedge clk);
        wv[0] = 1'b0;
        while (edge_cnt < a + 2 * LAT + 3) @(negedge clk);
        rv[0] = 1'b0;
        $display("ch0 RD+WR addr=05 wdata=44 rdata=%02h done_edge=%0d", rdat[0], a + 2 * LAT + 3);
        check("lit_rw_both", 32'(rdat[0]), 32'h44);
        repeat (2) @(negedge clk);

        // Held read valid must not produce a second ready.
        chan_op(1, 1'b0, 8'h02, 8'h00, 4, 2);
        check("lit_hold_rd", 32'(rdat[1]), 32'h09);

        // Randomised concurrent traffic on a small address window.
        fork
            rand_chan(0, 30); rand_chan(1, 30); rand_chan(2, 30); rand_chan(3, 30);
        join

        // Reset in the middle of a ch2 write.
        chan_op(0, 1'b1, 8'h30, 8'h66, 0, 2);
        chan_op(1, 1'b0, 8'h30, 8'h00, 0, 2);
        @(negedge clk);
        chk_en = 1'b0;
        wa[2] = 8'h30; wd[2] = 8'hFF; wv[2] = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        wv[2] = 1'b0;
        #1;
        check("async_rst_rd_data1", 32'(rdat[1]), 32'h0);
        check("async_rst_wr_ready", 32'(wrdy), 32'h0);
        @(negedge clk);
        check("rst_rd_ready", 32'(rr), 32'h0);
        check("rst_wr_ready", 32'(wrdy), 32'h0);
        for (int c = 0; c < NC; c++) begin
            exp_rd_edge[c] = -1; exp_wr_edge[c] = -1; exp_rdata[c] = '0;
        end
        reset = 1'b0;
        chk_en = 1'b1;
        repeat (4) @(negedge clk);
        chan_op(0, 1'b0, 8'h30, 8'h00, 0, 2);
        check("lit_rst_keep", 32'(rdat[0]), 32'h66);

`ifdef DATA_MEM_HOST_PORT_EN
        @(negedge clk);
        h_en = 1'b1; h_a = 8'h40; h_d = 8'h5A;
        host_addr = 8'h40; host_data = 8'h5A; host_edge = edge_cnt + 1;
        @(negedge clk);
        h_en = 1'b0;
        chan_op(0, 1'b0, 8'h40, 8'h00, 0, 2);
        check("lit_host_data", 32'(rdat[0]), 32'h5A);
`endif

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
